// File: rtl/decoder_share_arbiter.sv
// rtl/decoder_share_arbiter.sv - round-robin sharing of one combinational code-converter decoder
module decoder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CODE_W  = 4,
  parameter int SETTLE  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*CODE_W-1:0]    req_code,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [CODE_W-1:0]            dec_in,
  input  logic [CODE_W-1:0]            dec_out,
  output logic                         rsp_valid,
  output logic [CODE_W-1:0]            rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  input  logic                         rsp_ack,
  output logic                         busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_id;
  logic [CNT_W-1:0]    r_cnt;
  logic [CODE_W-1:0]   r_dec_in;
  logic [CODE_W-1:0]   r_rsp_data;
  logic                w_found;
  logic [ID_W-1:0]     w_winner;
  logic [ID_W-1:0]     w_ptr_nxt;

  // Rotating priority search: first requester at or after the pointer, wrapping modulo NUM_REQ.
  // Scanning offsets from highest to lowest lets the closest one overwrite the others.
  always_comb begin
    int v_idx;
    w_found  = 1'b0;
    w_winner = '0;
    v_idx    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= NUM_REQ) begin
        v_idx = v_idx - NUM_REQ;
      end
      if (req[v_idx]) begin
        w_found  = 1'b1;
        w_winner = ID_W'(v_idx);
      end
    end
  end

  // Pointer moves to the requester just after the one served, wrapping for any NUM_REQ.
  always_comb begin
    w_ptr_nxt = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> SETTLE -> RESP -> IDLE; no grant on the ack edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_found)        w_state_nxt = S_SETTLE;
      S_SETTLE: if (r_cnt == '0)    w_state_nxt = S_RESP;
      S_RESP:   if (rsp_ack)        w_state_nxt = S_IDLE;
      default:                      w_state_nxt = S_IDLE;
    endcase
  end

  // Transaction datapath: latch winner and its code at grant, capture decoder after settling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_id       <= '0;
      r_cnt      <= '0;
      r_dec_in   <= '0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_id     <= w_winner;
            r_dec_in <= req_code[int'(w_winner)*CODE_W +: CODE_W];
            r_cnt    <= CNT_W'(SETTLE - 1);
          end
        end
        S_SETTLE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_rsp_data <= dec_out;
          end
        end
        S_RESP: begin
          if (rsp_ack) begin
            r_ptr <= w_ptr_nxt;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Outputs decoded from state; grant is held for the whole transaction.
  always_comb begin
    gnt       = '0;
    busy      = (r_state != S_IDLE);
    rsp_valid = (r_state == S_RESP);
    if (r_state != S_IDLE) begin
      gnt[r_id] = 1'b1;
    end
  end

  assign dec_in   = r_dec_in;
  assign rsp_data = r_rsp_data;
  assign rsp_id   = r_id;

endmodule
